// File: rtl/matrix_row_scanner_if.sv
// Frame input and column/row drive signals of the matrix row scanner.
// master = frame source side, slave = the scanner itself.
interface matrix_row_scanner_if;
  logic [127:0] frame_in;
  logic         frame_valid;
  logic         ser_data;
  logic         ser_clk;
  logic         ser_latch;
  logic [7:0]   row_sel;
  logic         blank;
  logic         frame_done;

  modport master (
    output frame_in, frame_valid,
    input  ser_data, ser_clk, ser_latch, row_sel, blank, frame_done
  );

  modport slave (
    input  frame_in, frame_valid,
    output ser_data, ser_clk, ser_latch, row_sel, blank, frame_done
  );
endinterface

// File: rtl/matrix_row_scanner.sv
// Double-buffered 8x16 frame scanner driving a 595-style column chain and a one-hot row select.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | after reset; waits for a pending or incoming frame
// S_LOAD  | copies shadow (or a same-cycle frame_in) into active, row 0
// S_SHIFT | clocks 16 column bits of the current row into the chain
// S_LATCH | one-cycle storage latch pulse with the display blanked
// S_HOLD  | current row lit for ROW_HOLD cycles, then next row or LOAD
module matrix_row_scanner #(
  parameter int CLK_DIV  = 4,
  parameter int ROW_HOLD = 1000
) (
  input  logic               clk,
  input  logic               rst,
  matrix_row_scanner_if.slave bus
);
  localparam int TMAX = (CLK_DIV > ROW_HOLD) ? CLK_DIV : ROW_HOLD;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] DIV_LOAD  = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(ROW_HOLD - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_LATCH, S_HOLD} state_t;

  state_t        state, state_n;
  logic [127:0]  shadow, active, active_n;
  logic          pending, pending_n;
  logic [2:0]    row, row_n;
  logic [3:0]    bit_idx, bit_n;
  logic [TW-1:0] tmr, tmr_n;
  logic          sdata_n, sclk_n, latch_n, blank_n, done_n;
  logic [7:0]    rowsel_n;
  logic          bit_start;
  logic [6:0]    bit_pos;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      row            <= '0;
      bit_idx        <= '0;
      tmr            <= '0;
      shadow         <= '0;
      active         <= '0;
      pending        <= 1'b0;
      bus.ser_data   <= 1'b0;
      bus.ser_clk    <= 1'b0;
      bus.ser_latch  <= 1'b0;
      bus.row_sel    <= 8'h00;
      bus.blank      <= 1'b1;
      bus.frame_done <= 1'b0;
    end else begin
      state          <= state_n;
      row            <= row_n;
      bit_idx        <= bit_n;
      tmr            <= tmr_n;
      active         <= active_n;
      pending        <= pending_n;
      if (bus.frame_valid) shadow <= bus.frame_in;
      bus.ser_data   <= sdata_n;
      bus.ser_clk    <= sclk_n;
      bus.ser_latch  <= latch_n;
      bus.row_sel    <= rowsel_n;
      bus.blank      <= blank_n;
      bus.frame_done <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    row_n     = row;
    bit_n     = bit_idx;
    tmr_n     = tmr;
    active_n  = active;
    pending_n = pending | bus.frame_valid;
    sdata_n   = bus.ser_data;
    sclk_n    = bus.ser_clk;
    latch_n   = 1'b0;
    blank_n   = bus.blank;
    rowsel_n  = bus.row_sel;
    done_n    = 1'b0;
    bit_start = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (pending || bus.frame_valid) state_n = S_LOAD;
      end
      S_LOAD: begin
        active_n  = bus.frame_valid ? bus.frame_in : shadow;
        pending_n = 1'b0;
        row_n     = '0;
        bit_n     = '0;
        bit_start = 1'b1;
        state_n   = S_SHIFT;
      end
      S_SHIFT: begin
        if (tmr != '0) begin
          tmr_n = tmr - 1'b1;
        end else if (!bus.ser_clk) begin
          sclk_n = 1'b1;
          tmr_n  = DIV_LOAD;
        end else if (bit_idx == 4'd15) begin
          sclk_n  = 1'b0;
          latch_n = 1'b1;
          blank_n = 1'b1;
          state_n = S_LATCH;
        end else begin
          bit_n     = bit_idx + 4'd1;
          bit_start = 1'b1;
        end
      end
      S_LATCH: begin
        blank_n  = 1'b0;
        rowsel_n = 8'h01 << row;
        tmr_n    = HOLD_LOAD;
        // outputs are registered, so the pulse is armed one cycle ahead of the last HOLD cycle
        done_n   = (row == 3'd7) && (ROW_HOLD == 1);
        state_n  = S_HOLD;
      end
      S_HOLD: begin
        done_n = (row == 3'd7) && (tmr == TW'(1));
        if (tmr != '0) begin
          tmr_n = tmr - 1'b1;
        end else if (row == 3'd7) begin
          state_n = S_LOAD;
        end else begin
          row_n     = row + 3'd1;
          bit_n     = '0;
          bit_start = 1'b1;
          state_n   = S_SHIFT;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // frame bit index is 127 - 16*row - bit, i.e. the complement of {row, bit}
    bit_pos = ~{row_n, bit_n};
    if (bit_start) begin
      sdata_n = active_n[bit_pos];
      sclk_n  = 1'b0;
      tmr_n   = DIV_LOAD;
    end
  end
endmodule

// File: tb/tb_matrix_row_scanner.sv
// Randomized bench for matrix_row_scanner against a frame-schedule reference model.
module tb_matrix_row_scanner;
  localparam int CD = 1;
  localparam int RH = 4;
  localparam int SH = 32 * CD;
  localparam int P  = SH + 1 + RH;
  localparam int FR = 8 * P + 1;

  logic clk = 1'b0;
  logic rst;
  matrix_row_scanner_if bus();

  matrix_row_scanner #(.CLK_DIV(CD), .ROW_HOLD(RH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit           started;
  int           t0;
  int           cyc;
  bit           m_pending;
  logic [127:0] m_shadow, m_active;
  logic [15:0]  chain;
  logic         sclk_prev;

  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int fpos();
    if (!started) return -1;
    return (cyc - t0 - 1) % FR;
  endfunction

  // expected {ser_clk, ser_latch, row_sel, blank, frame_done} for cycle n
  task automatic model_outs(input int n, output logic [11:0] ctrl, output bit sd_valid,
                            output logic sd, output int row);
    int off, k, f, p;
    logic sclk, latch, blk, done;
    logic [7:0] rs, prev;
    sclk = 1'b0; latch = 1'b0; blk = 1'b1; done = 1'b0; rs = 8'h00;
    sd_valid = 1'b1; sd = 1'b0; row = 0;
    if (started) begin
      off = n - t0 - 1;
      k = off / FR;
      f = off % FR;
      sd_valid = 1'b0;
      prev = (k > 0) ? 8'h80 : 8'h00;
      if (f == 0) begin
        rs  = prev;
        blk = (k == 0);
      end else begin
        row = (f - 1) / P;
        p   = (f - 1) % P;
        if (row > 0) prev = 8'h01 << (row - 1);
        blk = 1'b0;
        if (p < SH) begin
          rs       = prev;
          blk      = (k == 0) && (row == 0);
          sclk     = ((p / CD) % 2) == 1;
          sd_valid = 1'b1;
          sd       = m_active[127 - 16 * row - p / (2 * CD)];
        end else if (p == SH) begin
          rs    = prev;
          blk   = 1'b1;
          latch = 1'b1;
        end else begin
          rs   = 8'h01 << row;
          done = (row == 7) && (p == P - 1);
        end
      end
    end
    ctrl = {sclk, latch, rs, blk, done};
  endtask

  task automatic cycle(input bit r_in, input bit fv, input logic [127:0] fin);
    logic [11:0] ctrl_e;
    bit          sdv;
    logic        sde;
    int          r;
    rst             = r_in;
    bus.frame_valid = fv;
    bus.frame_in    = fin;
    @(posedge clk);
    if (r_in) begin
      started = 1'b0; m_shadow = '0; m_active = '0; m_pending = 1'b0;
    end else if (started) begin
      if ((cyc - t0 - 1) % FR == 0) begin
        m_active  = fv ? fin : m_shadow;
        m_pending = 1'b0;
        if (fv) m_shadow = fin;
      end else if (fv) begin
        m_shadow  = fin;
        m_pending = 1'b1;
      end
    end else begin
      if (fv) begin
        m_shadow  = fin;
        m_pending = 1'b1;
      end
      if (m_pending) begin
        started = 1'b1;
        t0      = cyc;
      end
    end
    cyc++;
    @(negedge clk);
    model_outs(cyc, ctrl_e, sdv, sde, r);
    check_val("ctrl", {bus.ser_clk, bus.ser_latch, bus.row_sel, bus.blank, bus.frame_done}, ctrl_e);
    if (sdv) check_val("ser_data", bus.ser_data, sde);
    if (bus.ser_clk && !sclk_prev) chain = {chain[14:0], bus.ser_data};
    sclk_prev = bus.ser_clk;
    if (ctrl_e[10]) check_val("chain_word", chain, m_active[127 - 16 * r -: 16]);
  endtask

  task automatic seek(input int pos);
    for (int i = 0; i < 3 * FR && fpos() != pos; i++) cycle(1'b0, 1'b0, rnd128());
    check_val("seek", fpos() == pos, 1'b1);
  endtask

  initial begin
    started = 1'b0; t0 = 0; cyc = 0; m_pending = 1'b0;
    m_shadow = '0; m_active = '0; chain = '0; sclk_prev = 1'b0;
    rst = 1'b1; bus.frame_valid = 1'b0; bus.frame_in = '0;

    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    repeat (20000) cycle(1'b0, 1'b0, rnd128());

    // row 0 = A5F0, other rows blank
    cycle(1'b0, 1'b1, {16'hA5F0, 112'h0});
    repeat (2 * FR + 20) cycle(1'b0, 1'b0, '0);

    // new all-ones frame during row 3 SHIFT only shows from the next frame
    seek(1 + 3 * P + 5);
    cycle(1'b0, 1'b1, {128{1'b1}});
    repeat (2 * FR) cycle(1'b0, 1'b0, rnd128());

    // mid-frame write, then a different frame_in in the LOAD cycle wins
    seek(1 + 2 * P);
    cycle(1'b0, 1'b1, rnd128());
    seek(0);
    cycle(1'b0, 1'b1, rnd128());
    repeat (2 * FR) cycle(1'b0, 1'b0, '0);

    // sporadic random frames at random times
    for (int i = 0; i < 3 * FR; i++) cycle(1'b0, ($urandom_range(0, 199) == 0), rnd128());

    // reset mid-SHIFT of row 3, stay idle, then restart
    seek(1 + 3 * P + 7);
    cycle(1'b1, 1'b0, '0);
    repeat (500) cycle(1'b0, 1'b0, rnd128());
    cycle(1'b0, 1'b1, rnd128());
    repeat (FR + 50) cycle(1'b0, 1'b0, rnd128());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/matrix_row_scanner.md
# matrix_row_scanner

Display-side consumer of the 128-bit time bitmap produced by the time-to-bitmap block. It captures an 8×16 frame and drives an external 16-bit serial-in/parallel-out column register chain (595-style). It scans the eight rows one at a time through a one-hot row select, blanking the display around each row change. The frame is double-buffered, so the display only ever shows complete frames.

## Interface
- CLK_DIV, 4: half-period of ser_clk in clk cycles; must be ≥1.
- ROW_HOLD, 1000: clk cycles a row stays lit after its latch; must be ≥1.
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- frame_in  in  128  bitmap; row r = frame_in[127-16r -: 16]; bit 127 = row 0, leftmost column.
- frame_valid  in  1  frame_in is sampled in every cycle this is high.
- ser_data  out  1  column bit to the shift chain.
- ser_clk  out  1  shift clock; the chain samples ser_data on its rising edge.
- ser_latch  out  1  one-cycle storage-register latch pulse.
- row_sel  out  8  one-hot row enable, active-high; bit r = row r.
- blank  out  1  column output-enable blanking, active-high.
- frame_done  out  1  one-cycle pulse at the end of each displayed frame.

## Operation
- Buffers:
  - shadow (128 b), pending flag, active (128 b).
  - frame_valid=1: shadow <= frame_in and pending <= 1. Last write wins.
- States: IDLE, LOAD, SHIFT, LATCH, HOLD. Row counter: 3 bits, wraps 7→0.
- IDLE: entered on reset. Stays here until pending=1 or frame_valid=1, then goes to LOAD.
- LOAD, one cycle:
  - active <= shadow and pending <= 0.
  - If frame_valid=1 in this cycle, active <= frame_in instead (bypass); pending stays 0.
  - row <= 0, then go to SHIFT.
- SHIFT: sends 16 bits of the current row, starting with frame bit 127-16r and ending with bit 112-16r.
  - Per bit: ser_data is set at the start of the bit, ser_clk=0 for CLK_DIV cycles, then ser_clk=1 for CLK_DIV cycles.
  - ser_data is stable for the whole bit.
  - After bit 15, go to LATCH.
- LATCH, one cycle: ser_latch=1, blank=1, ser_clk=0. Go to HOLD.
- HOLD, ROW_HOLD cycles:
  - row_sel = 1<<row and blank=0 from the first HOLD cycle.
  - At the end, if row<7: row <= row+1, go to SHIFT.
  - If row=7: frame_done=1 in the last HOLD cycle, go to LOAD.
- The previous row stays lit while the next row shifts. Blank is high only during LATCH (plus IDLE/LOAD before the first row).
- No new frame arrived: LOAD copies the unchanged shadow, so the current frame is redisplayed.
- A frame_valid mid-frame never alters active. It takes effect at the next LOAD.

## Timing
- Reset values: ser_data=0, ser_clk=0, ser_latch=0, row_sel=8'h00, blank=1, frame_done=0. State=IDLE, row=0, shadow=0, active=0, pending=0.
- rst mid-operation: all of the above apply on the next clk edge, whatever the state. A new frame_valid is required to restart.
- All outputs are registered.
- frame_valid at cycle t, from IDLE: LOAD at t+1, first SHIFT cycle at t+2.
- SHIFT lasts 32·CLK_DIV cycles. Row period P = 32·CLK_DIV + 1 + ROW_HOLD. Frame period = 8·P + 1 (includes LOAD).
- Defaults: P=1129, frame=9033 cycles.
- frame_done pulses are exactly one frame period apart in steady state.
- row_sel changes only on the cycle after LATCH; blank is 1 on that edge's preceding cycle.

## Test plan
1. Reset held 2 cycles, then no frame_valid for 20000 cycles → outputs stay at reset values, ser_clk never toggles.
2. Setup: CLK_DIV=1, ROW_HOLD=4, row 0 = 16'hA5F0, other rows 0, frame_valid at cycle 0.
   - ser_clk rising edges 1..16 see ser_data 1,0,1,0,0,1,0,1,1,1,1,1,0,0,0,0.
   - ser_latch high at cycle 34.
   - row_sel=8'h01 and blank=0 at cycle 35.
3. Same setup:
   - row_sel steps 01,02,04,…,80, then back to 01; row changes 37 cycles apart.
   - blank high for exactly one cycle per row.
   - frame_done pulses are 297 cycles apart.
4. New frame (all ones) with frame_valid during row 3 SHIFT:
   - rows 3–7 of the current frame still shift the old data.
   - the next frame shifts all ones.
5. frame_valid=1 in the LOAD cycle with a value different from shadow → the next frame shifts the frame_in value (bypass), and pending=0 afterwards.
6. rst for 1 cycle mid-SHIFT of row 3 → next cycle row_sel=0, blank=1, ser_clk=0; the block stays in IDLE until the next frame_valid.
